// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: control bundle between the multi-cycle main controller and
// the MIPS datapath.
//
// Signals (direction as seen by the controller, modport master):
//   in  Op[5:0]     IR[31:26] opcode field
//   in  Funct[5:0]  IR[5:0] R-type function field
//   in  Zero        ALU zero flag
//   in  MemReady    memory access completes this cycle
//   out PCWrite     load PC from NPC at this edge
//   out NPCOp[1:0]  next-PC source (NPC_* codes below)
//   out IRWrite     load instruction register
//   out RegWrite    register file write enable
//   out RegDst[1:0] 0 rt, 1 rd, 2 $31
//   out WDSel[1:0]  0 ALU result, 1 memory data, 2 PC+4
//   out MemWrite    data memory write enable
//   out ALUSrc      0 register B, 1 extended immediate
//   out EXTOp       1 sign-extend, 0 zero-extend
//   out ALUOp[2:0]  0 add, 1 sub, 2 decode Funct, 3 or, 4 lui
//   out InstrDone   pulse in the cycle PCWrite is high
//   out Illegal     pulse in ID on an unsupported opcode
// The datapath side uses modport slave.

`ifndef NPC_PLUS4
`define NPC_PLUS4    2'd0
`endif
`ifndef NPC_BRANCH
`define NPC_BRANCH   2'd1
`endif
`ifndef NPC_JUMP_IMM
`define NPC_JUMP_IMM 2'd2
`endif
`ifndef NPC_JUMP_REG
`define NPC_JUMP_REG 2'd3
`endif

interface mc_ctrl_if;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite;
  logic [1:0] NPCOp;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] RegDst;
  logic [1:0] WDSel;
  logic       MemWrite;
  logic       ALUSrc;
  logic       EXTOp;
  logic [2:0] ALUOp;
  logic       InstrDone;
  logic       Illegal;

  modport master (
    input  Op, Funct, Zero, MemReady,
    output PCWrite, NPCOp, IRWrite, RegWrite, RegDst, WDSel,
           MemWrite, ALUSrc, EXTOp, ALUOp, InstrDone, Illegal
  );

  modport slave (
    output Op, Funct, Zero, MemReady,
    input  PCWrite, NPCOp, IRWrite, RegWrite, RegDst, WDSel,
           MemWrite, ALUSrc, EXTOp, ALUOp, InstrDone, Illegal
  );
endinterface

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS main controller. A five-state FSM
// (IF, ID, EXE, MEM, WB) that sequences each instruction and asserts
// PCWrite exactly once, in the instruction's final state.
//
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset; forces IF and holds all outputs at 0
//   bus  mc_ctrl_if.master: decode fields and flags in, datapath enables out
//
// All outputs are combinational from state, Op, Funct, Zero and MemReady.

module mc_ctrl (
  input  logic         clk,
  input  logic         rst,
  mc_ctrl_if.master    bus
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] FN_JR   = 6'b001000;

  state_e state_q, state_d;

  // Opcode decode
  logic is_r, is_jr, is_lw, is_sw, is_beq, is_j, is_jal;
  logic is_addi, is_ori, is_lui, is_supported;

  assign is_r         = (bus.Op == OP_R);
  assign is_jr        = is_r && (bus.Funct == FN_JR);
  assign is_lw        = (bus.Op == OP_LW);
  assign is_sw        = (bus.Op == OP_SW);
  assign is_beq       = (bus.Op == OP_BEQ);
  assign is_j         = (bus.Op == OP_J);
  assign is_jal       = (bus.Op == OP_JAL);
  assign is_addi      = (bus.Op == OP_ADDI);
  assign is_ori       = (bus.Op == OP_ORI);
  assign is_lui       = (bus.Op == OP_LUI);
  assign is_supported = is_r | is_lw | is_sw | is_beq | is_j | is_jal |
                        is_addi | is_ori | is_lui;

  // NOTE: state register uses non-blocking assignment; all combinational
  // logic below uses blocking assignment inside always_comb.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IF;
    else     state_q <= state_d;
  end

  logic       pc_write, ir_write, reg_write, mem_write;
  logic       alu_src, ext_op, illegal;
  logic [1:0] npc_op, reg_dst, wd_sel;
  logic [2:0] alu_op;

  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_d   = state_q;
    pc_write  = 1'b0;
    npc_op    = `NPC_PLUS4;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    reg_dst   = 2'd0;
    wd_sel    = 2'd0;
    mem_write = 1'b0;
    alu_src   = 1'b0;
    ext_op    = 1'b0;
    alu_op    = 3'd0;
    illegal   = 1'b0;

    unique case (state_q)
      S_IF: begin
        ir_write = bus.MemReady;
        if (bus.MemReady) state_d = S_ID;
      end

      S_ID: begin
        if (is_j || is_jal) begin
          pc_write = 1'b1;
          npc_op   = `NPC_JUMP_IMM;
          if (is_jal) begin
            reg_write = 1'b1;
            reg_dst   = 2'd2;
            wd_sel    = 2'd2;
          end
          state_d = S_IF;
        end else if (is_jr) begin
          pc_write = 1'b1;
          npc_op   = `NPC_JUMP_REG;
          state_d  = S_IF;
        end else if (!is_supported) begin
          // Unknown opcode retires as a nop so the core keeps running.
          illegal  = 1'b1;
          pc_write = 1'b1;
          state_d  = S_IF;
        end else begin
          state_d = S_EXE;
        end
      end

      S_EXE: begin
        if (is_r) begin
          alu_op = 3'd2;
        end else if (is_addi || is_lw || is_sw) begin
          alu_src = 1'b1;
          ext_op  = 1'b1;
        end else if (is_ori) begin
          alu_src = 1'b1;
          alu_op  = 3'd3;
        end else if (is_lui) begin
          alu_src = 1'b1;
          alu_op  = 3'd4;
        end else if (is_beq) begin
          alu_op = 3'd1;
        end

        if (is_beq) begin
          // Zero reflects rs-rt from this cycle's subtraction.
          pc_write = 1'b1;
          npc_op   = bus.Zero ? `NPC_BRANCH : `NPC_PLUS4;
          state_d  = S_IF;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end

      S_MEM: begin
        // Store data must be held on the bus for the whole access, stall included.
        mem_write = is_sw;
        if (bus.MemReady) begin
          if (is_sw) begin
            pc_write = 1'b1;
            state_d  = S_IF;
          end else begin
            state_d = S_WB;
          end
        end
      end

      S_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        reg_dst   = is_r  ? 2'd1 : 2'd0;
        wd_sel    = is_lw ? 2'd1 : 2'd0;
        state_d   = S_IF;
      end

      default: state_d = S_IF;
    endcase

    // Reset masks every output so an interrupted instruction never writes.
    if (rst) begin
      pc_write  = 1'b0;
      npc_op    = 2'd0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      reg_dst   = 2'd0;
      wd_sel    = 2'd0;
      mem_write = 1'b0;
      alu_src   = 1'b0;
      ext_op    = 1'b0;
      alu_op    = 3'd0;
      illegal   = 1'b0;
    end
  end

  assign bus.PCWrite   = pc_write;
  assign bus.NPCOp     = npc_op;
  assign bus.IRWrite   = ir_write;
  assign bus.RegWrite  = reg_write;
  assign bus.RegDst    = reg_dst;
  assign bus.WDSel     = wd_sel;
  assign bus.MemWrite  = mem_write;
  assign bus.ALUSrc    = alu_src;
  assign bus.EXTOp     = ext_op;
  assign bus.ALUOp     = alu_op;
  assign bus.InstrDone = pc_write;
  assign bus.Illegal   = illegal;

endmodule
